// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter block.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_arb_pkg;

  // Arbiter sequencing: accept, let the ALU sample, capture its result, hand it back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int FUNCT_W_DEF = 6;
  localparam int PERF_W      = 16;

  // ALU opcode map; the arbiter forwards any code untouched.
  localparam logic [5:0] FUNCT_SADD = 6'd0;
  localparam logic [5:0] FUNCT_SSUB = 6'd1;
  localparam logic [5:0] FUNCT_UADD = 6'd2;
  localparam logic [5:0] FUNCT_USUB = 6'd3;
  localparam logic [5:0] FUNCT_AND  = 6'd4;
  localparam logic [5:0] FUNCT_OR   = 6'd5;
  localparam logic [5:0] FUNCT_SHL  = 6'd6;
  localparam logic [5:0] FUNCT_SHR  = 6'd7;
  localparam logic [5:0] FUNCT_SLT  = 6'd8;

  // Saturating increment for the per-requester completion counters.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= NUM_L) begin
        cand = cand - NUM_L;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                      = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters, round-robin, one op in flight (ALU_ARB_PERF_EN adds completion counters).
// Latency: accept to rsp_valid is 3 clocks; a new op can be accepted every 4 clocks at best.
// Backpressure: rsp_valid/rsp_result hold until the granted requester's rsp_ready; no new request is accepted meanwhile.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FUNCT_W = FUNCT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*FUNCT_W-1:0] req_funct,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [FUNCT_W-1:0]       alu_funct,
  input  logic [DATA_W-1:0]        alu_result,
  output logic                     busy
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_W-1:0] perf_ops
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     win_idx_q;
  logic [NUM_REQ-1:0]   grant_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  logic                 load_op;
  logic                 capture;
  logic                 done;

  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic [FUNCT_W-1:0]   sel_funct;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // One-hot operand mux driven by the arbiter's grant.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    sel_funct = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_a     = req_a[i*DATA_W +: DATA_W];
        sel_b     = req_b[i*DATA_W +: DATA_W];
        sel_funct = req_funct[i*FUNCT_W +: FUNCT_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake strobes; ready only ever rises in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    load_op   = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (arb_any) begin
          req_ready = arb_grant;
          load_op   = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = CAPT;
      end
      CAPT: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = grant_q;
        if (|(rsp_ready & grant_q)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the winner and its operands at accept; alu_* then hold until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      win_idx_q <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_funct <= FUNCT_W'(FUNCT_UADD);
    end else if (load_op) begin
      grant_q   <= arb_grant;
      win_idx_q <= arb_idx;
      alu_a     <= sel_a;
      alu_b     <= sel_b;
      alu_funct <= sel_funct;
    end
  end

  // The ALU output is valid in CAPT; keep it stable through RESP and beyond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
    end else if (capture) begin
      rsp_result <= alu_result;
    end
  end

  // After a completed response the winner drops to lowest priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (done) begin
      rr_ptr_q <= (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ*PERF_W-1:0] perf_q;

  // Per-requester saturating count of responses taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (done) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          perf_q[i*PERF_W +: PERF_W] <= sat_inc(perf_q[i*PERF_W +: PERF_W]);
        end
      end
    end
  end

  assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic against a transaction-level model.
// Latency: model expects rsp_valid 3 clocks after accept.
// Backpressure: random rsp_ready exercises response holding.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic [N*FW-1:0]   req_funct;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_result;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [FW-1:0]     alu_funct;
  logic [DW-1:0]     alu_result;
  logic              busy;
`ifdef ALU_ARB_PERF_EN
  logic [N*16-1:0]   perf_ops;
`endif

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FUNCT_W(FW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_funct  (req_funct),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_funct  (alu_funct),
    .alu_result (alu_result),
    .busy       (busy)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_ops   (perf_ops)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU operation table.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    case (f)
      FUNCT_SADD, FUNCT_UADD: return a + b;
      FUNCT_SSUB, FUNCT_USUB: return a - b;
      FUNCT_AND:  return a & b;
      FUNCT_OR:   return a | b;
      FUNCT_SHL:  return a << b[4:0];
      FUNCT_SHR:  return a >> b[4:0];
      FUNCT_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:    return a + b;
    endcase
  endfunction

  // External single-cycle registered ALU.
  always @(posedge clk) alu_result <= alu_ref(alu_a, alu_b, alu_funct);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester drivers.
  logic        pv [N];
  logic [31:0] pa [N];
  logic [31:0] pb [N];
  logic [5:0]  pf [N];
  logic        rr [N];
  bit          refill;

  // Transaction-level model.
  bit          m_busy;
  int          m_owner, m_age, m_ptr;
  logic [31:0] m_res, m_last, m_opa, m_opb;
  logic [5:0]  m_opf;
  int unsigned m_cnt [N];
  int          grants_q[$];
  logic [31:0] res_q[$];

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = pv[i];
      req_a[i*DW +: DW]        = pa[i];
      req_b[i*DW +: DW]        = pb[i];
      req_funct[i*FW +: FW]    = pf[i];
      rsp_ready[i]             = rr[i];
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0;
    m_res = '0; m_last = '0; m_opa = '0; m_opb = '0; m_opf = FUNCT_UADD;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic check_cycle();
    logic [N-1:0] er, ev;
    logic [63:0]  eperf;
    int w;
    bit found;
    er = '0; ev = '0; w = 0; found = 0; eperf = '0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!found && pv[(m_ptr + k) % N]) begin
          found = 1;
          w = (m_ptr + k) % N;
        end
      end
      if (found) er[w] = 1'b1;
    end else if (m_age >= 3) begin
      ev[m_owner] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("rsp_result", 64'(rsp_result), 64'(m_last));
    chk("alu_a", 64'(alu_a), 64'(m_opa));
    chk("alu_b", 64'(alu_b), 64'(m_opb));
    chk("alu_funct", 64'(alu_funct), 64'(m_opf));
`ifdef ALU_ARB_PERF_EN
    for (int i = 0; i < N; i++) eperf[i*16 +: 16] = 16'(m_cnt[i]);
    chk("perf_ops", 64'(perf_ops), eperf);
`endif
    if (m_busy) begin
      if (m_age >= 3) begin
        if (rr[m_owner]) begin
          res_q.push_back(rsp_result);
          if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
          m_ptr  = (m_owner + 1) % N;
          m_busy = 0;
        end
      end else begin
        if (m_age == 2) m_last = m_res;
        m_age++;
      end
    end else if (found) begin
      m_busy  = 1;
      m_owner = w;
      m_age   = 1;
      m_res   = alu_ref(pa[w], pb[w], pf[w]);
      m_opa   = pa[w];
      m_opb   = pb[w];
      m_opf   = pf[w];
      grants_q.push_back(w);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) pv[i] = refill;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply_inputs();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      rr[i] = 1'b1;
    end
    for (int k = 0; k < 20 && m_busy; k++) step();
    step();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_funct"}, 64'(alu_funct), 64'd2);
`ifdef ALU_ARB_PERF_EN
    chk({tag, "_perf"}, 64'(perf_ops), 64'd0);
`endif
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0; rr[i] = 1'b0; pa[i] = '0; pb[i] = '0; pf[i] = '0;
    end
    apply_inputs();
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One isolated operation from an idle arbiter.
  task automatic single(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] f, input logic [31:0] exp);
    int lat;
    pv[idx] = 1'b1; pa[idx] = a; pb[idx] = b; pf[idx] = f; rr[idx] = 1'b1;
    step();
    chk({tag, "_ready"}, 64'(req_ready), 64'd1 << idx);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rsp_valid[idx]) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_result"}, 64'(rsp_result), 64'(exp));
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    refill = 0;
    model_reset();
    #2;
    do_reset("por");
    step();

    // Single request from requester 0.
    single("t1", 0, 32'd5, 32'd3, FUNCT_UADD, 32'd8);

    // Reset while a SUB sits in CAPT: nothing must come back, pointer restarts at 0.
    for (int i = 0; i < N; i++) rr[i] = 1'b1;
    pv[1] = 1'b1; pa[1] = 32'd9; pb[1] = 32'd4; pf[1] = FUNCT_USUB;
    step(); step(); step();
    do_reset("midop");
    for (int i = 0; i < N; i++) rr[i] = 1'b1;
    repeat (3) step();

    // All four requesting continuously.
    grants_q.delete(); res_q.delete();
    refill = 1;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1; pa[i] = 32'(i); pb[i] = 32'd10; pf[i] = FUNCT_UADD; rr[i] = 1'b1;
    end
    repeat (17) step();
    refill = 0;
    drain();
    chk("t2_grant_count", 64'(grants_q.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      chk("t2_grant_order", 64'((k < grants_q.size()) ? grants_q[k] : -1), 64'(k % N));
    for (int k = 0; k < 4; k++)
      chk("t2_result", (k < res_q.size()) ? 64'(res_q[k]) : 64'hDEAD, 64'(10 + k));

    // Response backpressure on requester 2 while requester 1 waits.
    for (int i = 0; i < N; i++) rr[i] = 1'b1;
    rr[2] = 1'b0;
    pv[2] = 1'b1; pa[2] = 32'hF0; pb[2] = 32'h0F; pf[2] = FUNCT_OR;
    repeat (4) step();
    pv[1] = 1'b1; pa[1] = 32'd7; pb[1] = 32'd1; pf[1] = FUNCT_UADD;
    repeat (5) begin
      step();
      chk("t3_hold_valid", 64'(rsp_valid), 64'b0100);
      chk("t3_hold_result", 64'(rsp_result), 64'hFF);
      chk("t3_r1_waits", 64'(req_ready), 64'd0);
    end
    rr[2] = 1'b1;
    step();
    step();
    chk("t3_r1_accept", 64'(req_ready), 64'b0010);
    drain();

    // Funct pass-through, including an undefined code.
    single("t5_shl", 3, 32'd1, 32'd4, FUNCT_SHL, 32'd16);
    single("t5_undef", 3, 32'd2, 32'd2, 6'h3F, 32'd4);

`ifdef ALU_ARB_PERF_EN
    do_reset("perf");
    step();
    repeat (3) single("p_cnt", 1, 32'd1, 32'd1, FUNCT_AND, 32'd1);
    chk("perf_three", 64'(perf_ops), 64'h0000_0000_0003_0000);
    force dut.perf_q = 64'h0000_0000_FFFF_0000;
    #1;
    release dut.perf_q;
    m_cnt[1] = 65535;
    single("p_sat_op", 1, 32'd3, 32'd1, FUNCT_SHR, 32'd1);
    chk("perf_saturated", 64'(perf_ops), 64'h0000_0000_FFFF_0000);
`endif

    // Random traffic with random response backpressure.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) begin
          pv[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = $urandom;
          pf[i] = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(9, 63)) : 6'($urandom_range(0, 8));
        end
        rr[i] = ($urandom_range(0, 9) < 7);
      end
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered ALU among NUM_REQ requesters, such as the decode/execute stage and the address-generation helpers. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, drives the ALU operand and funct inputs, and accounts for the ALU's one-clock registered latency. It then returns the result to the winning requester only. At most one operation is in flight.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width; must match the ALU
FUNCT_W, 6, ALU opcode width

Ports:
clk  in  1  single clock; ALU shares the same clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept strobe
req_a  in  NUM_REQ*DATA_W  operand a, requester i at slice [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand b, same packing
req_funct  in  NUM_REQ*FUNCT_W  opcode, same packing
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response accept
rsp_result  out  DATA_W  shared result bus; valid for the requester whose rsp_valid is high
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_funct  out  FUNCT_W  to ALU funct
alu_result  in  DATA_W  from ALU result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - state=IDLE, rr_ptr=0, grant register=0
  - alu_a=0, alu_b=0, alu_funct=6'b000010 (unsigned add)
  - rsp_result=0, rsp_valid=0, busy=0
- FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, pick a winner round-robin starting at rr_ptr.
  - req_ready[winner]=1 combinationally in this cycle only.
  - Register the winner's a/b/funct into alu_a/alu_b/alu_funct, store the one-hot grant, go to EXEC.
  - Nothing valid: stay in IDLE, all outputs hold.
- EXEC: alu_* held stable; the ALU samples them at the closing edge. Go to CAPT.
- CAPT: alu_result is valid; register it into rsp_result. Go to RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_result is held stable.
  - On rsp_ready[grant]=1: go to IDLE and set rr_ptr=(winner+1) mod NUM_REQ.
  - Otherwise hold indefinitely (backpressure). rsp_ready of non-granted requesters is ignored.
- Latency and throughput: request accept to rsp_valid is 3 clocks; minimum issue interval is 4 clocks.
- req_ready is only ever high in IDLE. Requests arriving in EXEC/CAPT/RESP wait; a request dropped before its grant leaves no trace.
- Requesters must hold req_valid and operands until req_ready. Operands are consumed only in the accept cycle.
- Simultaneous requests: exactly one one-hot grant is issued. The granted requester has lowest priority in the next arbitration.
- The arbiter passes funct through unmodified, including undefined codes; the ALU default applies.
- alu_* keep their last values outside EXEC; no re-zeroing.
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and the block returns to the reset state immediately.

Optional Feature:
ALU_ARB_PERF_EN:
- Defined: adds output perf_ops [NUM_REQ*16], per-requester 16-bit saturating counters of completed responses. A counter increments on RESP&&rsp_ready for that requester, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_arb_pkg:
  - state enum (IDLE, EXEC, CAPT, RESP)
  - DATA_W/FUNCT_W default constants
  - ALU funct localparams: FUNCT_SADD=0, SSUB=1, UADD=2, USUB=3, AND=4, OR=5, SHL=6, SHR=7, SLT=8
- Sub-module rr_arbiter: NUM_REQ-wide request vector plus rr_ptr in, one-hot grant and encoded index out, purely combinational. It is reused by the top FSM.

Test Plan:
1. Single request: requester 0 sends a=5, b=3, funct=UADD -> req_ready[0] pulses once; rsp_valid[0] 3 clocks later with rsp_result=8.
2. All four request continuously with rsp_ready=1, requester i sending a=i, b=10, funct=UADD -> grant order 0,1,2,3,0; results 10,11,12,13; one grant per 4 clocks.
3. Backpressure: requester 2 sends a=0xF0, b=0x0F, funct=OR; rsp_ready[2]=0 for 5 clocks -> rsp_valid[2] and rsp_result=0xFF held; requester 1's pending request not accepted until rsp_ready[2]=1.
4. Reset: rst_n dropped in CAPT of a SUB -> all outputs return to reset values asynchronously; no rsp_valid after release; the next request is granted from rr_ptr=0.
5. Pass-through: requester 3 sends a=1, b=4, funct=SHL -> rsp_result=16. Requester 3 then sends funct=6'b111111, a=2, b=2 -> rsp_result=4 (ALU default add).
6. With ALU_ARB_PERF_EN: 3 completions on requester 1 -> perf_ops slice 1 reads 3, others 0; a forced count of 16'hFFFF stays saturated after a further completion.
